// File: rtl/dram_init_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dram_init_fsm_pkg
// Description : Command encoding shared by the DDR3 init sequencer, its
//               interface and the PHY command stage.
// Revision    : 1.0 - initial release
// ============================================================================
package dram_init_fsm_pkg;

  typedef enum logic [2:0] {
    CMD_NOP      = 3'd0,
    CMD_RESET    = 3'd1,
    CMD_POWER_UP = 3'd2,
    CMD_MRS      = 3'd3,
    CMD_ZQCAL    = 3'd4
  } command_t;

endpackage
`default_nettype wire

// File: rtl/dram_init_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : dram_init_fsm_if
// Description : Start/command/status bundle between the init sequencer
//               (master) and the PHY command stage plus its controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface dram_init_fsm_if;
  import dram_init_fsm_pkg::*;

  logic       i_start;
  command_t   o_command;
  logic [1:0] o_mode_register_num;
  logic       o_init_busy;
  logic       o_init_done;
  logic [3:0] o_init_state;

  modport master (
    input  i_start,
    output o_command,
    output o_mode_register_num,
    output o_init_busy,
    output o_init_done,
    output o_init_state
  );

  modport slave (
    output i_start,
    input  o_command,
    input  o_mode_register_num,
    input  o_init_busy,
    input  o_init_done,
    input  o_init_state
  );

endinterface
`default_nettype wire

// File: rtl/dram_init_fsm.sv
`default_nettype none
// ============================================================================
// Module      : dram_init_fsm
// Description : DDR3 power-up initialization sequencer. Walks through
//               RESET# low, CKE low, tXPR, MRS MR2/MR3/MR1/MR0, ZQCL and
//               tZQinit, then raises a sticky done flag. All outputs are
//               registered from the current state, so every command appears
//               one clock after the state that produces it is entered.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_init_fsm
  import dram_init_fsm_pkg::*;
#(
  parameter int T_RESET  = 4,
  parameter int T_CKE    = 5,
  parameter int T_XPR    = 3,
  parameter int T_MRD    = 4,
  parameter int T_MOD    = 12,
  parameter int T_ZQINIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic           clk1,
  input  logic           rst_n,
  dram_init_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_RESET    = 4'd1,
    S_CKE      = 4'd2,
    S_XPR      = 4'd3,
    S_MRS      = 4'd4,
    S_MRS_WAIT = 4'd5,
    S_ZQ       = 4'd6,
    S_ZQ_WAIT  = 4'd7,
    S_DONE     = 4'd8
  } state_t;

  // Counter load values: duration-1 for plain hold states. The MRS and ZQCL
  // states take one cycle themselves, so their trailing waits load duration-2.
  localparam logic [CNT_W-1:0] LD_RESET = CNT_W'(T_RESET - 1);
  localparam logic [CNT_W-1:0] LD_CKE   = CNT_W'(T_CKE - 1);
  localparam logic [CNT_W-1:0] LD_XPR   = CNT_W'(T_XPR - 1);
  localparam logic [CNT_W-1:0] LD_MRD   = CNT_W'(T_MRD - 2);
  localparam logic [CNT_W-1:0] LD_MOD   = CNT_W'(T_MOD - 2);
  localparam logic [CNT_W-1:0] LD_ZQ    = CNT_W'(T_ZQINIT - 2);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [1:0]       mr_idx;
  logic [1:0]       mr_idx_next;
  logic             cnt_zero;

  command_t         command_next;
  logic [1:0]       mr_num_next;
  logic             busy_next;
  logic             done_next;

  assign cnt_zero = (cnt == '0);

  // State, timing counter, MRS sequence index and registered outputs.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state                   <= S_IDLE;
      cnt                     <= '0;
      mr_idx                  <= 2'd0;
      bus.o_command           <= CMD_RESET;
      bus.o_mode_register_num <= 2'd0;
      bus.o_init_busy         <= 1'b0;
      bus.o_init_done         <= 1'b0;
      bus.o_init_state        <= S_IDLE;
    end else begin
      state                   <= state_next;
      cnt                     <= cnt_next;
      mr_idx                  <= mr_idx_next;
      bus.o_command           <= command_next;
      bus.o_mode_register_num <= mr_num_next;
      bus.o_init_busy         <= busy_next;
      bus.o_init_done         <= done_next;
      bus.o_init_state        <= state;
    end
  end

  // Next-state sequencing plus the output values implied by the current state.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    mr_idx_next  = mr_idx;
    command_next = CMD_NOP;
    mr_num_next  = 2'd0;
    busy_next    = 1'b1;
    done_next    = 1'b0;

    case (state)
      S_IDLE: begin
        command_next = CMD_RESET;
        busy_next    = 1'b0;
        if (bus.i_start) begin
          state_next  = S_RESET;
          cnt_next    = LD_RESET;
          mr_idx_next = 2'd0;
        end
      end
      S_RESET: begin
        command_next = CMD_RESET;
        if (cnt_zero) begin
          state_next = S_CKE;
          cnt_next   = LD_CKE;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      S_CKE: begin
        command_next = CMD_POWER_UP;
        if (cnt_zero) begin
          state_next = S_XPR;
          cnt_next   = LD_XPR;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      S_XPR: begin
        if (cnt_zero) begin
          state_next = S_MRS;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      S_MRS: begin
        // Issue order MR2, MR3, MR1, MR0 for index 0..3.
        command_next = CMD_MRS;
        case (mr_idx)
          2'd0:    mr_num_next = 2'd2;
          2'd1:    mr_num_next = 2'd3;
          2'd2:    mr_num_next = 2'd1;
          default: mr_num_next = 2'd0;
        endcase
        state_next = S_MRS_WAIT;
        // After MR0 the gap to ZQCL is tMOD rather than tMRD.
        cnt_next   = (mr_idx == 2'd3) ? LD_MOD : LD_MRD;
      end
      S_MRS_WAIT: begin
        if (cnt_zero) begin
          if (mr_idx == 2'd3) begin
            state_next = S_ZQ;
          end else begin
            state_next  = S_MRS;
            mr_idx_next = mr_idx + 2'd1;
          end
          cnt_next = '0;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      S_ZQ: begin
        command_next = CMD_ZQCAL;
        state_next   = S_ZQ_WAIT;
        cnt_next     = LD_ZQ;
      end
      S_ZQ_WAIT: begin
        if (cnt_zero) begin
          state_next = S_DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      S_DONE: begin
        busy_next = 1'b0;
        done_next = 1'b1;
      end
      default: begin
        state_next   = S_IDLE;
        cnt_next     = '0;
        mr_idx_next  = 2'd0;
        command_next = CMD_RESET;
        busy_next    = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_dram_init_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_dram_init_fsm
// Description : Self-checking bench for the DDR3 init sequencer. Two
//               instances run side by side: default timing and a short
//               tMRD/tMOD/tZQinit variant. Expected outputs come from a
//               timeline model computed directly from the cycle formulas.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_init_fsm;
  import dram_init_fsm_pkg::*;

  localparam int TR    = 4;
  localparam int TC    = 5;
  localparam int TX    = 3;
  localparam int A_MRD = 4;
  localparam int A_MOD = 12;
  localparam int A_ZQ  = 16;
  localparam int B_MRD = 2;
  localparam int B_MOD = 2;
  localparam int B_ZQ  = 2;
  localparam int RUN_LEN = 75;

  logic clk1  = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  dram_init_fsm_if ifa ();
  dram_init_fsm_if ifb ();

  dram_init_fsm u_dut_a (
    .clk1  (clk1),
    .rst_n (rst_n),
    .bus   (ifa.master)
  );

  dram_init_fsm #(
    .T_MRD    (B_MRD),
    .T_MOD    (B_MOD),
    .T_ZQINIT (B_ZQ)
  ) u_dut_b (
    .clk1  (clk1),
    .rst_n (rst_n),
    .bus   (ifb.master)
  );

  // Free-running clock.
  always #5 clk1 = ~clk1;

  // Expected outputs n cycles after the start-sampling edge (n<=0: idle).
  function automatic void model(input int n, input int tm, input int tmo, input int tz,
                                output command_t cmd, output logic [1:0] mr,
                                output logic busy, output logic done);
    int mrtab [4];
    int k;
    int z;
    int d;
    mrtab = '{2, 3, 1, 0};
    k = 1 + TR + TC + TX;
    z = k + 3 * tm + tmo;
    d = z + tz;
    cmd  = CMD_NOP;
    mr   = 2'd0;
    busy = (n >= 1) && (n < d);
    done = (n >= d);
    if (n <= TR)
      cmd = CMD_RESET;
    else if (n <= TR + TC)
      cmd = CMD_POWER_UP;
    else if ((n >= k) && (n <= k + 3 * tm) && (((n - k) % tm) == 0)) begin
      cmd = CMD_MRS;
      mr  = 2'(mrtab[(n - k) / tm]);
    end else if (n == z)
      cmd = CMD_ZQCAL;
  endfunction

  task automatic apply_reset();
    ifa.i_start = 1'b0;
    ifb.i_start = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk1);
    #1;
    rst_n = 1'b1;
  endtask

  // Starts both DUTs (next posedge is cycle 0) and checks cycles 1..len.
  // mode: 0 = single pulse, 1 = held high, 2 = random after acceptance.
  task automatic run_timeline(input int mode, input int len, input bit full);
    command_t   ec;
    logic [1:0] emr;
    logic       eb;
    logic       ed;
    int ma = 0;
    int za = 0;
    int mb = 0;
    int zb = 0;
    ifa.i_start = 1'b1;
    ifb.i_start = 1'b1;
    @(posedge clk1);
    #1;
    for (int n = 1; n <= len; n++) begin
      logic s;
      s = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      ifa.i_start = s;
      ifb.i_start = s;
      @(posedge clk1);
      #1;
      model(n, A_MRD, A_MOD, A_ZQ, ec, emr, eb, ed);
      checks += 4;
      if (ifa.o_command !== ec) begin
        errors++;
        $display("FAIL A.command n=%0d got=%0d exp=%0d", n, ifa.o_command, ec);
      end
      if (ifa.o_mode_register_num !== emr) begin
        errors++;
        $display("FAIL A.mr_num n=%0d got=%0d exp=%0d", n, ifa.o_mode_register_num, emr);
      end
      if (ifa.o_init_busy !== eb) begin
        errors++;
        $display("FAIL A.busy n=%0d got=%0b exp=%0b", n, ifa.o_init_busy, eb);
      end
      if (ifa.o_init_done !== ed) begin
        errors++;
        $display("FAIL A.done n=%0d got=%0b exp=%0b", n, ifa.o_init_done, ed);
      end
      model(n, B_MRD, B_MOD, B_ZQ, ec, emr, eb, ed);
      checks += 4;
      if (ifb.o_command !== ec) begin
        errors++;
        $display("FAIL B.command n=%0d got=%0d exp=%0d", n, ifb.o_command, ec);
      end
      if (ifb.o_mode_register_num !== emr) begin
        errors++;
        $display("FAIL B.mr_num n=%0d got=%0d exp=%0d", n, ifb.o_mode_register_num, emr);
      end
      if (ifb.o_init_busy !== eb) begin
        errors++;
        $display("FAIL B.busy n=%0d got=%0b exp=%0b", n, ifb.o_init_busy, eb);
      end
      if (ifb.o_init_done !== ed) begin
        errors++;
        $display("FAIL B.done n=%0d got=%0b exp=%0b", n, ifb.o_init_done, ed);
      end
      if (ifa.o_command == CMD_MRS)   ma++;
      if (ifa.o_command == CMD_ZQCAL) za++;
      if (ifb.o_command == CMD_MRS)   mb++;
      if (ifb.o_command == CMD_ZQCAL) zb++;
    end
    if (full) begin
      checks += 4;
      if (ma !== 4) begin
        errors++;
        $display("FAIL A.mrs_count got=%0d exp=4", ma);
      end
      if (za !== 1) begin
        errors++;
        $display("FAIL A.zq_count got=%0d exp=1", za);
      end
      if (mb !== 4) begin
        errors++;
        $display("FAIL B.mrs_count got=%0d exp=4", mb);
      end
      if (zb !== 1) begin
        errors++;
        $display("FAIL B.zq_count got=%0d exp=1", zb);
      end
    end
  endtask

  // Reset values hold while rst_n is low even with i_start asserted.
  task automatic test_reset();
    rst_n = 1'b0;
    ifa.i_start = 1'b1;
    ifb.i_start = 1'b1;
    repeat (3) begin
      @(posedge clk1);
      #1;
      checks += 5;
      if (ifa.o_command !== CMD_RESET) begin
        errors++;
        $display("FAIL reset.A.command got=%0d exp=%0d", ifa.o_command, CMD_RESET);
      end
      if (ifa.o_mode_register_num !== 2'd0) begin
        errors++;
        $display("FAIL reset.A.mr_num got=%0d exp=0", ifa.o_mode_register_num);
      end
      if (ifa.o_init_busy !== 1'b0) begin
        errors++;
        $display("FAIL reset.A.busy got=%0b exp=0", ifa.o_init_busy);
      end
      if (ifa.o_init_done !== 1'b0) begin
        errors++;
        $display("FAIL reset.A.done got=%0b exp=0", ifa.o_init_done);
      end
      if (ifb.o_command !== CMD_RESET) begin
        errors++;
        $display("FAIL reset.B.command got=%0d exp=%0d", ifb.o_command, CMD_RESET);
      end
    end
    ifa.i_start = 1'b0;
    ifb.i_start = 1'b0;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk1);
      #1;
      checks += 2;
      if (ifa.o_init_busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_release.A.busy got=%0b exp=0", ifa.o_init_busy);
      end
      if (ifa.o_command !== CMD_RESET) begin
        errors++;
        $display("FAIL reset_release.A.command got=%0d exp=%0d", ifa.o_command, CMD_RESET);
      end
    end
  endtask

  task automatic test_pulse_start();
    apply_reset();
    run_timeline(0, RUN_LEN, 1'b1);
  endtask

  task automatic test_held_start();
    apply_reset();
    run_timeline(1, RUN_LEN, 1'b1);
  endtask

  // Random idle gap, then random i_start activity throughout the sequence.
  task automatic test_random_start();
    int gap;
    apply_reset();
    gap = int'($urandom_range(0, 6));
    for (int c = 0; c < gap; c++) begin
      @(posedge clk1);
      #1;
      checks++;
      if (ifa.o_init_busy !== 1'b0 || ifa.o_command !== CMD_RESET) begin
        errors++;
        $display("FAIL random_gap.A busy=%0b cmd=%0d exp busy=0 cmd=%0d",
                 ifa.o_init_busy, ifa.o_command, CMD_RESET);
      end
    end
    run_timeline(2, RUN_LEN, 1'b1);
  endtask

  // Reset asynchronously during the MRS phase, then restart at cycle 30.
  task automatic test_mid_reset();
    apply_reset();
    run_timeline(0, 20, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks += 6;
    if (ifa.o_command !== CMD_RESET) begin
      errors++;
      $display("FAIL midrst.A.command got=%0d exp=%0d", ifa.o_command, CMD_RESET);
    end
    if (ifa.o_init_busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst.A.busy got=%0b exp=0", ifa.o_init_busy);
    end
    if (ifa.o_init_done !== 1'b0) begin
      errors++;
      $display("FAIL midrst.A.done got=%0b exp=0", ifa.o_init_done);
    end
    if (ifa.o_mode_register_num !== 2'd0) begin
      errors++;
      $display("FAIL midrst.A.mr_num got=%0d exp=0", ifa.o_mode_register_num);
    end
    if (ifb.o_command !== CMD_RESET) begin
      errors++;
      $display("FAIL midrst.B.command got=%0d exp=%0d", ifb.o_command, CMD_RESET);
    end
    if (ifb.o_init_busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst.B.busy got=%0b exp=0", ifb.o_init_busy);
    end
    @(posedge clk1);
    #1;
    rst_n = 1'b1;
    for (int c = 22; c <= 29; c++) begin
      @(posedge clk1);
      #1;
      checks++;
      if (ifa.o_init_busy !== 1'b0 || ifa.o_command !== CMD_RESET) begin
        errors++;
        $display("FAIL midrst_idle.A c=%0d busy=%0b cmd=%0d exp busy=0 cmd=%0d",
                 c, ifa.o_init_busy, ifa.o_command, CMD_RESET);
      end
    end
    run_timeline(0, RUN_LEN, 1'b1);
  endtask

  // Without i_start the device stays held in reset indefinitely.
  task automatic test_idle_1000();
    apply_reset();
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk1);
      #1;
      checks += 2;
      if (ifa.o_command !== CMD_RESET || ifa.o_init_done !== 1'b0 || ifa.o_init_busy !== 1'b0) begin
        errors++;
        $display("FAIL idle.A c=%0d cmd=%0d done=%0b busy=%0b exp cmd=%0d done=0 busy=0",
                 c, ifa.o_command, ifa.o_init_done, ifa.o_init_busy, CMD_RESET);
      end
      if (ifb.o_command !== CMD_RESET || ifb.o_init_done !== 1'b0) begin
        errors++;
        $display("FAIL idle.B c=%0d cmd=%0d done=%0b exp cmd=%0d done=0",
                 c, ifb.o_command, ifb.o_init_done, CMD_RESET);
      end
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    ifa.i_start = 1'b0;
    ifb.i_start = 1'b0;
    test_reset();
    test_pulse_start();
    test_held_start();
    test_random_start();
    test_mid_reset();
    test_idle_1000();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound in case the run stalls.
  initial begin
    #1000000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
